// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: word width, fetch FSM encoding, PC defaults.
package cpu_pkg;

  localparam int unsigned XLEN = 32;

  typedef logic [XLEN-1:0] word_t;

  localparam word_t RESET_PC_DEFAULT = 32'h0000_0000;
  localparam word_t TRAP_PC_DEFAULT  = 32'h0000_0080;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_WAIT = 2'd2
  } fetch_state_e;

  // A redirect request: valid flag plus destination address.
  typedef struct packed {
    logic  valid;
    word_t target;
  } redirect_t;

  // True when an address is not word aligned.
  function automatic logic is_misaligned(input word_t addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Fetch-stage bus: PC / imem handshake plus redirect and hazard inputs.
interface pc_fetch_unit_if;
  import cpu_pkg::*;

  word_t pcp4_in;
  logic  stall;
  logic  branch_taken;
  word_t branch_target;
  logic  jump;
  word_t jump_target;
  logic  imem_ready;
  word_t pc;
  logic  imem_req;
  logic  if_valid;
  logic  misalign_trap;

  // Fetch unit side: owns the PC and IF/ID flags.
  modport master (
    input  pcp4_in, stall, branch_taken, branch_target, jump, jump_target, imem_ready,
    output pc, imem_req, if_valid, misalign_trap
  );

  // Environment side: incrementer, hazard unit, ID stage and imem.
  modport slave (
    output pcp4_in, stall, branch_taken, branch_target, jump, jump_target, imem_ready,
    input  pc, imem_req, if_valid, misalign_trap
  );

endinterface

// File: rtl/pc_redirect_mux.sv
// Combinational redirect selection: jump over branch over pending target,
// followed by alignment legalisation.
// PC_MISALIGN_TRAP_EN: misaligned targets divert to TRAP_PC and raise trap_c;
// otherwise the low two target bits are cleared and trap_c stays 0.
module pc_redirect_mux
  import cpu_pkg::*;
#(
  parameter word_t TRAP_PC = TRAP_PC_DEFAULT
) (
  input  logic      jump,
  input  word_t     jump_target,
  input  logic      branch_taken,
  input  word_t     branch_target,
  input  logic      pend,
  input  word_t     pending_pc,
  output redirect_t new_c,
  output redirect_t target_c,
  output logic      trap_c
);

  word_t raw;

`ifndef PC_MISALIGN_TRAP_EN
  // Low address bits and trap vector have no role when traps are disabled.
  logic unused_bits;
  assign unused_bits = ^{TRAP_PC, raw[1:0]};
`endif

  // Priority select and legalisation of the redirect destination.
  always_comb begin
    new_c           = '0;
    target_c        = '0;
    trap_c          = 1'b0;
    raw             = pending_pc;

    new_c.valid     = jump | branch_taken;
    new_c.target    = jump ? jump_target : branch_target;

    if (new_c.valid) begin
      raw = new_c.target;
    end
    target_c.valid  = new_c.valid | pend;

`ifdef PC_MISALIGN_TRAP_EN
    trap_c          = target_c.valid && is_misaligned(raw);
    target_c.target = trap_c ? TRAP_PC : raw;
`else
    target_c.target = {raw[XLEN-1:2], 2'b00};
`endif
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// IF-stage program counter owner: BOOT/RUN/WAIT sequencing, redirects,
// stalls, imem wait states and the IF/ID valid flag.
// Optional macro PC_MISALIGN_TRAP_EN routes misaligned redirects to TRAP_PC.
module pc_fetch_unit
  import cpu_pkg::*;
#(
  parameter word_t RESET_PC = RESET_PC_DEFAULT,
  parameter word_t TRAP_PC  = TRAP_PC_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  pc_fetch_unit_if.master    bus
);

  fetch_state_e state;
  logic         pend;
  word_t        pending_pc;
  redirect_t    new_c;
  redirect_t    target_c;
  logic         trap_c;

  pc_redirect_mux #(
    .TRAP_PC (TRAP_PC)
  ) u_redirect_mux (
    .jump          (bus.jump),
    .jump_target   (bus.jump_target),
    .branch_taken  (bus.branch_taken),
    .branch_target (bus.branch_target),
    .pend          (pend),
    .pending_pc    (pending_pc),
    .new_c         (new_c),
    .target_c      (target_c),
    .trap_c        (trap_c)
  );

  // Fetch FSM with registered PC, request, valid and trap outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= ST_BOOT;
      pend              <= 1'b0;
      pending_pc        <= '0;
      bus.pc            <= RESET_PC;
      bus.imem_req      <= 1'b0;
      bus.if_valid      <= 1'b0;
      bus.misalign_trap <= 1'b0;
    end else begin
      bus.misalign_trap <= 1'b0;
      case (state)
        ST_BOOT: begin
          bus.imem_req <= 1'b1;
          state        <= ST_RUN;
        end

        ST_RUN: begin
          if (new_c.valid) begin
            bus.pc            <= target_c.target;
            bus.if_valid      <= 1'b0;
            bus.misalign_trap <= trap_c;
          end else if (bus.stall) begin
            // hold pc and if_valid
          end else if (!bus.imem_ready) begin
            bus.if_valid <= 1'b0;
            state        <= ST_WAIT;
          end else begin
            bus.pc       <= bus.pcp4_in;
            bus.if_valid <= 1'b1;
          end
        end

        ST_WAIT: begin
          if (bus.imem_ready) begin
            state <= ST_RUN;
            pend  <= 1'b0;
            if (target_c.valid) begin
              // same-cycle redirect wins, else the latched one
              bus.pc            <= target_c.target;
              bus.if_valid      <= 1'b0;
              bus.misalign_trap <= trap_c;
            end else if (bus.stall) begin
              bus.if_valid <= 1'b0;
            end else begin
              bus.pc       <= bus.pcp4_in;
              bus.if_valid <= 1'b1;
            end
          end else if (new_c.valid) begin
            // pc must stay put; remember the latest redirect
            pend       <= 1'b1;
            pending_pc <= new_c.target;
          end
        end

        default: begin
          state <= ST_BOOT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: directed vectors push expected
// post-edge outputs; a negedge monitor pops and compares.
module tb_pc_fetch_unit;
  import cpu_pkg::*;

  typedef struct packed {
    word_t pc;
    logic  if_valid;
    logic  imem_req;
    logic  trap;
  } exp_t;

`ifdef PC_MISALIGN_TRAP_EN
  localparam word_t MIS_PC   = 32'h0000_0080;
  localparam logic  MIS_TRAP = 1'b1;
`else
  localparam word_t MIS_PC   = 32'h0000_0100;
  localparam logic  MIS_TRAP = 1'b0;
`endif

  logic clk;
  logic rst_n;
  pc_fetch_unit_if bus();

  exp_t exp_q[$];
  int   n_pass;
  int   n_total;
  int   step_no;

  pc_fetch_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // External incrementer model
  assign bus.pcp4_in = bus.pc + 32'd4;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  // Monitor: compare DUT outputs against the oldest expected entry
  always @(negedge clk) begin
    if (rst_n && exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      step_no++;
      chk($sformatf("step%0d_pc", step_no), 64'(bus.pc), 64'(e.pc));
      chk($sformatf("step%0d_if_valid", step_no), 64'(bus.if_valid), 64'(e.if_valid));
      chk($sformatf("step%0d_imem_req", step_no), 64'(bus.imem_req), 64'(e.imem_req));
      chk($sformatf("step%0d_trap", step_no), 64'(bus.misalign_trap), 64'(e.trap));
    end
  end

  // Drive one cycle of inputs and push the expected state after the edge
  task automatic step(input logic st, input logic br, input word_t bt,
                      input logic j, input word_t jt, input logic rdy,
                      input word_t epc, input logic ev, input logic etrap);
    exp_t e;
    bus.stall         = st;
    bus.branch_taken  = br;
    bus.branch_target = bt;
    bus.jump          = j;
    bus.jump_target   = jt;
    bus.imem_ready    = rdy;
    e.pc       = epc;
    e.if_valid = ev;
    e.imem_req = 1'b1;
    e.trap     = etrap;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input word_t epc, input logic ev);
    step(1'b0, 1'b0, '0, 1'b0, '0, 1'b1, epc, ev, 1'b0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_pc"}, 64'(bus.pc), 64'(RESET_PC_DEFAULT));
    chk({tag, "_imem_req"}, 64'(bus.imem_req), 64'd0);
    chk({tag, "_if_valid"}, 64'(bus.if_valid), 64'd0);
    chk({tag, "_trap"}, 64'(bus.misalign_trap), 64'd0);
  endtask

  initial begin
    n_pass = 0; n_total = 0; step_no = 0;
    rst_n = 1'b1;
    bus.stall = 1'b0; bus.branch_taken = 1'b0; bus.branch_target = '0;
    bus.jump = 1'b0; bus.jump_target = '0; bus.imem_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1 chk_reset("reset_async");
    repeat (2) @(posedge clk);
    #1 chk_reset("reset_held");
    @(negedge clk); #1 rst_n = 1'b1;

    // Boot then sequential fetch
    idle(32'h00, 1'b0);
    idle(32'h04, 1'b1);
    idle(32'h08, 1'b1);
    idle(32'h0C, 1'b1);
    idle(32'h10, 1'b1);
    // Stall three cycles at 0x10
    step(1'b1, 1'b0, '0, 1'b0, '0, 1'b1, 32'h10, 1'b1, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0, '0, 1'b1, 32'h10, 1'b1, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0, '0, 1'b1, 32'h10, 1'b1, 1'b0);
    idle(32'h14, 1'b1);
    idle(32'h18, 1'b1);
    idle(32'h1C, 1'b1);
    idle(32'h20, 1'b1);
    // Branch with simultaneous stall at 0x20
    step(1'b1, 1'b1, 32'h100, 1'b0, '0, 1'b1, 32'h100, 1'b0, 1'b0);
    idle(32'h104, 1'b1);
    // Stall outranks imem not ready in RUN
    step(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, 32'h104, 1'b1, 1'b0);
    // Jump to 0x3C to reach 0x40
    step(1'b0, 1'b0, '0, 1'b1, 32'h3C, 1'b1, 32'h3C, 1'b0, 1'b0);
    idle(32'h40, 1'b1);
    // imem wait at 0x40, jump latched during wait cycle 2
    step(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 32'h40, 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 32'h40, 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1, 32'h200, 1'b0, 32'h40, 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 32'h40, 1'b0, 1'b0);
    idle(32'h200, 1'b0);
    idle(32'h204, 1'b1);
    // Wait, then ready with stall: hold pc, bubble
    step(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 32'h204, 1'b0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0, '0, 1'b1, 32'h204, 1'b0, 1'b0);
    idle(32'h208, 1'b1);
    // Wait, then plain ready: advance
    step(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 32'h208, 1'b0, 1'b0);
    idle(32'h20C, 1'b1);
    // Wait, redirect in same cycle as ready
    step(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 32'h20C, 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'h500, 1'b0, '0, 1'b1, 32'h500, 1'b0, 1'b0);
    idle(32'h504, 1'b1);
    // Jump beats branch
    step(1'b0, 1'b1, 32'h400, 1'b1, 32'h300, 1'b1, 32'h300, 1'b0, 1'b0);
    idle(32'h304, 1'b1);
    // Misaligned jump target
    step(1'b0, 1'b0, '0, 1'b1, 32'h102, 1'b1, MIS_PC, 1'b0, MIS_TRAP);
    idle(MIS_PC + 32'd4, 1'b1);
    // Later pending redirect overwrites earlier one
    step(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, MIS_PC + 32'd4, 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'h600, 1'b0, '0, 1'b0, MIS_PC + 32'd4, 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1, 32'h700, 1'b0, MIS_PC + 32'd4, 1'b0, 1'b0);
    idle(32'h700, 1'b0);
    idle(32'h704, 1'b1);
    // Enter WAIT with a pending jump, then reset asynchronously
    step(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 32'h704, 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1, 32'h900, 1'b0, 32'h704, 1'b0, 1'b0);
    @(negedge clk); #1 rst_n = 1'b0;
    #1 chk_reset("reset_mid_wait");
    @(posedge clk); #1 chk_reset("reset_mid_wait_held");
    @(negedge clk); #1 rst_n = 1'b1;
    idle(32'h00, 1'b0);
    // Pending redirect must be gone after reset
    step(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 32'h00, 1'b0, 1'b0);
    idle(32'h04, 1'b1);
    idle(32'h08, 1'b1);

    @(negedge clk); #1;
    chk("queue_drain", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
